ibex_rf_scrub_ctrl: RTL and testbench
=====================================

// Module: ibex_rf_scrub_ctrl
// PURPOSE
// Background scrubber/scheduler for the ECC-protected register file. Steals idle cycles on read port B
// and write port A to walk x1..x(N-1), check each word via the external SECDED decoder, and write back
// corrected data. Raises alerts on uncorrectable words. Sits in ibex_core beside the register file;
// the core always has priority on both ports.
// PARAMETERS
// RV32E          0   1: scan x1..x15, else x1..x31
// DataWidth      39  stored word width (data + ECC)
// ScrubInterval  16  idle cycles between consecutive scrub reads (>=1)
// ErrCntWidth    8   width of saturating correctable-error counter
// PORTS
// clk_i           in   1            clock
// rst_ni          in   1            async active-low reset
// scrub_en_i      in   1            scrubbing enabled (CSR)
// core_rd_b_i     in   1            core uses read port B this cycle
// core_we_i       in   1            core writes port A this cycle
// core_waddr_i    in   5            core write address
// scrub_rd_o      out  1            scrubber owns read port B (raddr_b muxed to scrub_raddr_o)
// scrub_raddr_o   out  5            scrub read address
// rdata_i         in   DataWidth    raw word on rdata_b (combinational read, same cycle)
// ecc_err_i       in   2            decoder result for rdata_i: [0] correctable, [1] uncorrectable
// corr_data_i     in   DataWidth    re-encoded corrected word from decoder
// scrub_we_o      out  1            scrubber owns write port A
// scrub_waddr_o   out  5            write-back address
// scrub_wdata_o   out  DataWidth    write-back data
// alert_major_o   out  1            1-cycle pulse: uncorrectable word found
// alert_minor_o   out  1            1-cycle pulse: correctable word repaired
// err_cnt_o       out  ErrCntWidth  saturating count of repairs
// pass_done_o     out  1            1-cycle pulse when address wraps to x1
// BEHAVIOUR
// - Reset: all outputs 0, addr reg = 1, interval counter = 0, state IDLE, err_cnt = 0.
// - States: IDLE -> WAIT on scrub_en_i. WAIT: count idle cycles; at ScrubInterval-1 -> READ.
// - READ: scrub_rd_o = !core_rd_b_i (core wins; retry every cycle). On grant sample ecc_err_i/corr_data_i:
//   none -> advance addr, WAIT; [1] set -> alert_major_o pulse, advance, WAIT;
//   [0] only -> latch corr_data, WRITE. [1] has priority over [0].
// - WRITE: scrub_we_o = !core_we_i. If core_we_i && core_waddr_i == addr: abort write (core data is
//   fresher), no repair counted, advance, WAIT. On write grant: alert_minor_o pulse, err_cnt++ (saturate at
//   all-ones), advance, WAIT.
// - Advance: addr == NUM_WORDS-1 -> addr = 1 and pass_done_o pulse; else addr+1. x0 never scanned.
// - scrub_en_i low in any state: next cycle IDLE, pending write dropped, addr and err_cnt retained,
//   interval counter cleared. No scrub_we_o/scrub_rd_o in the cycle after deassertion.
// - scrub_rd_o and scrub_we_o never asserted in the same cycle; scrub_*addr_o held stable while asserted.
// - Latency: clean word = interval + 1 granted cycle; repaired word = +1 granted write cycle.
// - Reset asserted mid-operation: immediate return to reset values, no write-back completes.
// STRUCTURE
// - ibex_pkg: scrub_state_e {SCRUB_IDLE, SCRUB_WAIT, SCRUB_READ, SCRUB_WRITE}; ScrubErrCorr/ScrubErrUncorr
//   bit indices. Single module, no sub-modules; interval counter and FSM in one always_ff.
// - Port muxing (core vs scrub) lives in ibex_core, not in this block.
// TESTING
// - Enable, no core traffic, ScrubInterval=4, clean words -> reads x1..x31 every 5 cycles, pass_done at x31->x1.
// - ecc_err_i=2'b01 at x5 -> WRITE x5 with corr_data next cycle, alert_minor pulse, err_cnt=1.
// - ecc_err_i=2'b11 at x7 -> alert_major only, no write, advance to x8.
// - Core holds core_rd_b_i 10 cycles in READ -> scrub_rd_o 0 throughout, read x3 on 11th cycle.
// - In WRITE x9, core_we_i=1, core_waddr_i=9 -> write aborted, err_cnt unchanged, next addr x10.
// - Deassert scrub_en_i in WRITE -> IDLE, no scrub_we_o; re-enable resumes at same addr.
// - err_cnt at 8'hFF + repair -> stays 8'hFF, alert_minor still pulses; RV32E=1 wraps x15->x1.

Source files
------------

// File: rtl/ibex_rf_scrub_ctrl_pkg.sv
// Shared definitions for the register-file scrubber.
//   scrub_state_e      : FSM state encoding (IDLE / WAIT / READ / WRITE)
//   ScrubErrCorr/Uncorr: bit positions inside the decoder's 2-bit error flag
//   scrub_next_addr()  : walk x1..last, skipping x0 on wrap
package ibex_rf_scrub_ctrl_pkg;

  typedef logic [1:0] scrub_state_e;

  localparam scrub_state_e SCRUB_IDLE  = 2'd0;
  localparam scrub_state_e SCRUB_WAIT  = 2'd1;
  localparam scrub_state_e SCRUB_READ  = 2'd2;
  localparam scrub_state_e SCRUB_WRITE = 2'd3;

  localparam int unsigned ScrubErrCorr   = 0;
  localparam int unsigned ScrubErrUncorr = 1;

  // x0 is hardwired zero and has no storage, so the walk wraps to x1.
  function automatic logic [4:0] scrub_next_addr(input logic [4:0] addr,
                                                 input logic [4:0] last);
    return (addr == last) ? 5'd1 : addr + 5'd1;
  endfunction

endpackage

// File: rtl/ibex_rf_scrub_ctrl.sv
// Background scrubber for the ECC-protected register file.
// Steals idle cycles on read port B / write port A to walk x1..x(N-1), checks
// each word through the external SECDED decoder and writes corrected words back.
// Ports:
//   clk_i, rst_ni                 clock, async active-low reset
//   scrub_en_i                    scrub enable (CSR)
//   core_rd_b_i                   core owns read port B this cycle (core wins)
//   core_we_i, core_waddr_i       core write on port A this cycle
//   scrub_rd_o, scrub_raddr_o     scrubber read request on port B
//   rdata_i                       raw word (decoded externally, not used here)
//   ecc_err_i, corr_data_i        decoder result and re-encoded corrected word
//   scrub_we_o, scrub_waddr_o,
//   scrub_wdata_o                 scrubber write-back on port A
//   alert_major_o / alert_minor_o 1-cycle pulses: uncorrectable / repaired word
//   err_cnt_o                     saturating repair count
//   pass_done_o                   1-cycle pulse when the walk wraps to x1
module ibex_rf_scrub_ctrl
  import ibex_rf_scrub_ctrl_pkg::*;
#(
  parameter bit          RV32E         = 1'b0,
  parameter int unsigned DataWidth     = 39,
  parameter int unsigned ScrubInterval = 16,
  parameter int unsigned ErrCntWidth   = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   scrub_en_i,
  input  logic                   core_rd_b_i,
  input  logic                   core_we_i,
  input  logic [4:0]             core_waddr_i,
  output logic                   scrub_rd_o,
  output logic [4:0]             scrub_raddr_o,
  input  logic [DataWidth-1:0]   rdata_i,
  input  logic [1:0]             ecc_err_i,
  input  logic [DataWidth-1:0]   corr_data_i,
  output logic                   scrub_we_o,
  output logic [4:0]             scrub_waddr_o,
  output logic [DataWidth-1:0]   scrub_wdata_o,
  output logic                   alert_major_o,
  output logic                   alert_minor_o,
  output logic [ErrCntWidth-1:0] err_cnt_o,
  output logic                   pass_done_o
);

  localparam logic [4:0]  LastAddr = RV32E ? 5'd15 : 5'd31;
  localparam int unsigned CntW     = (ScrubInterval > 1) ? $clog2(ScrubInterval) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(ScrubInterval - 1);

  scrub_state_e          state_q;
  logic [4:0]            addr_q;
  logic [CntW-1:0]       cnt_q;
  logic [DataWidth-1:0]  wdata_q;
  logic [ErrCntWidth-1:0] err_cnt_q;
  logic                  alert_major_q, alert_minor_q, pass_done_q;

  logic                  rd_grant, wr_grant, wr_clash, at_last;
  logic [4:0]            addr_nxt;

  // The decoder consumes rdata_i directly; the port is kept so the block
  // drops into the core wiring unchanged.
  logic unused_rdata;
  assign unused_rdata = ^rdata_i;

  // Gating with scrub_en_i makes a disable take effect on the ports in the
  // same cycle, so a write pending in WRITE is dropped rather than issued.
  assign rd_grant = scrub_en_i && (state_q == SCRUB_READ)  && !core_rd_b_i;
  assign wr_grant = scrub_en_i && (state_q == SCRUB_WRITE) && !core_we_i;
  // Core is writing the very word we meant to repair: its data is newer.
  assign wr_clash = core_we_i && (core_waddr_i == addr_q);
  assign at_last  = (addr_q == LastAddr);
  assign addr_nxt = scrub_next_addr(addr_q, LastAddr);

  assign scrub_rd_o    = rd_grant;
  assign scrub_we_o    = wr_grant;
  assign scrub_raddr_o = (state_q == SCRUB_READ)  ? addr_q : 5'd0;
  assign scrub_waddr_o = (state_q == SCRUB_WRITE) ? addr_q : 5'd0;
  assign scrub_wdata_o = wdata_q;
  assign alert_major_o = alert_major_q;
  assign alert_minor_o = alert_minor_q;
  assign err_cnt_o     = err_cnt_q;
  assign pass_done_o   = pass_done_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= SCRUB_IDLE;
      addr_q        <= 5'd1;
      cnt_q         <= '0;
      wdata_q       <= '0;
      err_cnt_q     <= '0;
      alert_major_q <= 1'b0;
      alert_minor_q <= 1'b0;
      pass_done_q   <= 1'b0;
    end else begin
      alert_major_q <= 1'b0;
      alert_minor_q <= 1'b0;
      pass_done_q   <= 1'b0;
      if (!scrub_en_i) begin
        state_q <= SCRUB_IDLE;
        cnt_q   <= '0;
      end else begin
        case (state_q)
          SCRUB_IDLE: begin
            state_q <= SCRUB_WAIT;
            cnt_q   <= '0;
          end
          SCRUB_WAIT: begin
            if (cnt_q == CntLast) begin
              state_q <= SCRUB_READ;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q + CntW'(1);
            end
          end
          SCRUB_READ: begin
            // Core owns port B: hold the request and retry next cycle.
            if (!core_rd_b_i) begin
              if (ecc_err_i[ScrubErrUncorr]) begin
                alert_major_q <= 1'b1;
                addr_q        <= addr_nxt;
                pass_done_q   <= at_last;
                state_q       <= SCRUB_WAIT;
              end else if (ecc_err_i[ScrubErrCorr]) begin
                wdata_q <= corr_data_i;
                state_q <= SCRUB_WRITE;
              end else begin
                addr_q      <= addr_nxt;
                pass_done_q <= at_last;
                state_q     <= SCRUB_WAIT;
              end
            end
          end
          SCRUB_WRITE: begin
            if (wr_clash) begin
              addr_q      <= addr_nxt;
              pass_done_q <= at_last;
              state_q     <= SCRUB_WAIT;
            end else if (!core_we_i) begin
              alert_minor_q <= 1'b1;
              if (err_cnt_q != '1) err_cnt_q <= err_cnt_q + ErrCntWidth'(1);
              addr_q      <= addr_nxt;
              pass_done_q <= at_last;
              state_q     <= SCRUB_WAIT;
            end
          end
          default: state_q <= SCRUB_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ibex_rf_scrub_ctrl.sv
module tb_ibex_rf_scrub_ctrl;
  localparam int DW = 39;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // main DUT: RV32I, interval 4
  logic          rst_n, en, core_rd_b, core_we;
  logic [4:0]    core_waddr;
  logic          scrub_rd, scrub_we, amaj, amin, pass;
  logic [4:0]    raddr, waddr;
  logic [DW-1:0] rdata, corr_data, wdata;
  logic [1:0]    ecc_err, inj_err;
  logic [7:0]    err_cnt;

  function automatic logic [DW-1:0] corr_word(input logic [4:0] a);
    return {7'h5A, 27'h0ABCDE0, a};
  endfunction

  assign ecc_err   = scrub_rd ? inj_err : 2'b00;
  assign rdata     = {34'h0, raddr};
  assign corr_data = corr_word(raddr);

  ibex_rf_scrub_ctrl #(.RV32E(1'b0), .DataWidth(DW), .ScrubInterval(4), .ErrCntWidth(8)) dut (
    .clk_i(clk), .rst_ni(rst_n), .scrub_en_i(en), .core_rd_b_i(core_rd_b),
    .core_we_i(core_we), .core_waddr_i(core_waddr), .scrub_rd_o(scrub_rd),
    .scrub_raddr_o(raddr), .rdata_i(rdata), .ecc_err_i(ecc_err), .corr_data_i(corr_data),
    .scrub_we_o(scrub_we), .scrub_waddr_o(waddr), .scrub_wdata_o(wdata),
    .alert_major_o(amaj), .alert_minor_o(amin), .err_cnt_o(err_cnt), .pass_done_o(pass));

  // second DUT: RV32E, interval 1, clean traffic only
  logic          e_rst_n, e_en, e_rd, e_we, e_amaj, e_amin, e_pass;
  logic [4:0]    e_raddr, e_waddr;
  logic [DW-1:0] e_wdata;
  logic [7:0]    e_cnt;
  logic          e_zero_b = 1'b0;
  logic [4:0]    e_zero_a = 5'd0;
  logic [1:0]    e_zero_e = 2'b00;
  logic [DW-1:0] e_zero_d = '0;

  ibex_rf_scrub_ctrl #(.RV32E(1'b1), .DataWidth(DW), .ScrubInterval(1), .ErrCntWidth(8)) dut_e (
    .clk_i(clk), .rst_ni(e_rst_n), .scrub_en_i(e_en), .core_rd_b_i(e_zero_b),
    .core_we_i(e_zero_b), .core_waddr_i(e_zero_a), .scrub_rd_o(e_rd),
    .scrub_raddr_o(e_raddr), .rdata_i(e_zero_d), .ecc_err_i(e_zero_e), .corr_data_i(e_zero_d),
    .scrub_we_o(e_we), .scrub_waddr_o(e_waddr), .scrub_wdata_o(e_wdata),
    .alert_major_o(e_amaj), .alert_minor_o(e_amin), .err_cnt_o(e_cnt), .pass_done_o(e_pass));

  int total = 0, bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // scoreboard of expected port grants, in order
  typedef struct {
    bit            wr;
    logic [4:0]    addr;
    logic [DW-1:0] data;
  } ev_t;
  ev_t q[$];
  ev_t mon_e;
  int  rd_cyc, wr_cyc, n_maj, n_min, n_pass;

  always @(negedge clk) begin
    if (rst_n) begin
      if (scrub_rd && scrub_we) chk("rd_we_overlap", 1, 0);
      if (scrub_rd || scrub_we) begin
        if (q.size() == 0) chk("unexpected_grant", longint'(scrub_rd | scrub_we), 0);
        else begin
          mon_e = q.pop_front();
          chk("grant_kind", longint'(scrub_we), longint'(mon_e.wr));
          if (scrub_rd) begin
            chk("rd_addr", raddr, mon_e.addr);
            rd_cyc = cyc;
          end else begin
            chk("wr_addr", waddr, mon_e.addr);
            chk("wr_data", wdata, mon_e.data);
            wr_cyc = cyc;
          end
        end
      end
      n_maj  += int'(amaj);
      n_min  += int'(amin);
      n_pass += int'(pass);
    end
  end

  task automatic wait_drain(input string nm);
    int n = 0;
    while (q.size() != 0 && n < 200) begin
      step();
      n++;
    end
    if (q.size() != 0) begin
      chk({nm, "_timeout"}, q.size(), 0);
      q.delete();
    end
  endtask

  // bench model of the walk
  int exp_addr = 1, exp_cnt = 0, prev_rd = 0;
  bit prev_wstate = 0;

  task automatic push_ev(input bit wr, input int a);
    ev_t e;
    e.wr   = wr;
    e.addr = 5'(a);
    e.data = wr ? corr_word(5'(a)) : '0;
    q.push_back(e);
  endtask

  task automatic run_vec(input logic [1:0] err, input bit abort);
    bit wst, wr;
    wst = err[0] && !err[1];
    wr  = wst && !abort;
    inj_err = err;
    if (abort) begin
      core_we    = 1'b1;
      core_waddr = 5'(exp_addr);
    end
    n_maj = 0; n_min = 0; n_pass = 0;
    push_ev(1'b0, exp_addr);
    if (wr) push_ev(1'b1, exp_addr);
    wait_drain("vec");
    step(); step();
    inj_err = 2'b00;
    core_we = 1'b0;
    chk("read_gap", rd_cyc - prev_rd, prev_wstate ? 6 : 5);
    if (wr) chk("write_latency", wr_cyc - rd_cyc, 1);
    if (wr && exp_cnt < 255) exp_cnt++;
    chk("alert_major", n_maj, int'(err[1]));
    chk("alert_minor", n_min, int'(wr));
    chk("pass_done", n_pass, int'(exp_addr == 31));
    chk("err_cnt", err_cnt, exp_cnt);
    prev_rd     = rd_cyc;
    prev_wstate = wst;
    exp_addr    = (exp_addr == 31) ? 1 : exp_addr + 1;
  endtask

  typedef struct {
    logic [1:0] err;
    bit         abort;
  } vec_t;
  vec_t tbl[33];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int e, r, n, n_ep;
    rst_n = 1'b0; e_rst_n = 1'b0; en = 1'b0; e_en = 1'b0;
    core_rd_b = 1'b0; core_we = 1'b0; core_waddr = 5'd0; inj_err = 2'b00;

    // vectors x1..x31 then x1,x2; defaults are clean
    for (int i = 0; i < 33; i++) begin
      tbl[i].err   = 2'b00;
      tbl[i].abort = 1'b0;
    end
    tbl[4].err  = 2'b01;                       // x5 repaired
    tbl[6].err  = 2'b11;                       // x7 uncorrectable wins
    tbl[8].err  = 2'b01; tbl[8].abort = 1'b1;  // x9 core overwrites
    tbl[11].err = 2'b10;                       // x12 uncorrectable
    tbl[19].err = 2'b01;                       // x20 repaired

    step(); step();
    chk("rst_outputs", {scrub_rd, scrub_we, amaj, amin, pass, raddr, waddr}, 0);
    chk("rst_err_cnt", err_cnt, 0);
    chk("rst_wdata", wdata, 0);
    rst_n = 1'b1;
    step(); step();
    chk("idle_outputs", {scrub_rd, scrub_we, amaj, amin, pass}, 0);

    en = 1'b1;
    prev_rd = cyc;     // IDLE, then 4 WAIT cycles: first read 5 cycles later
    prev_wstate = 1'b0;
    for (int i = 0; i < 33; i++) run_vec(tbl[i].err, tbl[i].abort);

    // core holds port B through 10 READ cycles before x3 gets in
    core_rd_b = 1'b1;
    n_maj = 0; n_min = 0; n_pass = 0;
    push_ev(1'b0, exp_addr);
    while (cyc < prev_rd + 15) step();
    core_rd_b = 1'b0;
    wait_drain("rd_hold");
    chk("rd_hold_grant_cycle", rd_cyc, prev_rd + 15);
    prev_rd = rd_cyc; prev_wstate = 1'b0; exp_addr++;
    step();

    // disable during WRITE: write dropped, address kept
    inj_err = 2'b01;
    n_min = 0;
    push_ev(1'b0, exp_addr);
    wait_drain("dis_rd");
    en = 1'b0;
    #1;
    chk("dis_we_blocked", scrub_we, 0);
    inj_err = 2'b00;
    for (int k = 0; k < 4; k++) step();
    chk("dis_minor", n_min, 0);
    chk("dis_err_cnt", err_cnt, exp_cnt);
    en = 1'b1;
    e = cyc;
    push_ev(1'b0, exp_addr);
    wait_drain("resume");
    chk("resume_latency", rd_cyc, e + 5);
    prev_rd = rd_cyc; prev_wstate = 1'b0; exp_addr++;
    step();

    // push the counter to saturation, then one more repair
    while (exp_cnt < 255) run_vec(2'b01, 1'b0);
    run_vec(2'b01, 1'b0);
    chk("sat_err_cnt", err_cnt, 8'hFF);

    // reset during the write cycle
    inj_err = 2'b01;
    push_ev(1'b0, exp_addr);
    wait_drain("rst_rd");
    rst_n = 1'b0;
    #1;
    chk("rst_mid_we", scrub_we, 0);
    chk("rst_mid_err_cnt", err_cnt, 0);
    inj_err = 2'b00;
    n_min = 0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("rst_mid_pulses", {amin, amaj, pass, scrub_we}, 0);
    end
    rst_n = 1'b1;
    r = cyc;
    push_ev(1'b0, 1);
    wait_drain("post_rst");
    chk("post_rst_latency", rd_cyc, r + 5);
    chk("post_rst_err_cnt", err_cnt, 0);
    en = 1'b0;

    // RV32E walk with interval 1: x1..x15, x1, x2
    e_rst_n = 1'b1;
    step();
    e_en = 1'b1;
    n_ep = 0;
    for (int k = 0; k < 17; k++) begin
      n = 0;
      do begin
        @(negedge clk);
        n_ep += int'(e_pass);
        n++;
      end while (!e_rd && n < 10);
      chk("e_rd_seen", e_rd, 1);
      chk("e_rd_addr", e_raddr, (k % 15) + 1);
      chk("e_no_we", e_we, 0);
    end
    chk("e_pass_count", n_ep, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
